// File: rtl/register_file_16_if.sv
// Bus bundle for register_file_16: write request, two read addresses,
// the combinational read results and the sticky multi-hot error flag.
interface register_file_16_if #(
    parameter int WIDTH = 16
);
    logic             RegWrite;
    logic [15:0]      WriteEnable;
    logic [WIDTH-1:0] WriteData;
    logic [3:0]       RS;
    logic [3:0]       RT;
    logic [WIDTH-1:0] ReadS;
    logic [WIDTH-1:0] ReadT;
    logic             MultiHotError;

    modport master (
        output RegWrite, WriteEnable, WriteData, RS, RT,
        input  ReadS, ReadT, MultiHotError
    );

    modport slave (
        input  RegWrite, WriteEnable, WriteData, RS, RT,
        output ReadS, ReadT, MultiHotError
    );
endinterface

// File: rtl/register_file_16.sv
// 16 x WIDTH register file: one-hot qualified write, two combinational read
// ports with same-cycle write-through bypass, hardwired-zero R0, sticky error.
module register_file_16 #(
    parameter int WIDTH = 16,
    parameter int NREGS = 16
) (
    input logic                CLK,
    input logic                Reset,
    register_file_16_if.slave  bus
);

    logic [WIDTH-1:0] regs      [NREGS];
    logic [WIDTH-1:0] regs_next [NREGS];
    logic [NREGS-1:0] reg_we;
    logic             write_valid;
    logic             write_multi;
    logic             error_flag;

    // A vector with more than one bit set still has bits left after clearing its lowest one.
    function automatic logic is_multi_hot(input logic [NREGS-1:0] vec);
        return (vec & (vec - 1'b1)) != '0;
    endfunction

    function automatic logic is_one_hot(input logic [NREGS-1:0] vec);
        return (vec != '0) && !is_multi_hot(vec);
    endfunction

    function automatic logic [WIDTH-1:0] read_port(
        input logic [3:0]       addr,
        input logic [NREGS-1:0] we_vec,
        input logic [WIDTH-1:0] wdata,
        input logic [WIDTH-1:0] stored
    );
        if (addr == 4'd0)
            return '0;
        else if (we_vec[addr])
            return wdata;
        else
            return stored;
    endfunction

    assign write_valid = bus.RegWrite && !Reset && is_one_hot(bus.WriteEnable);
    assign write_multi = bus.RegWrite && is_multi_hot(bus.WriteEnable);
    assign reg_we      = write_valid ? bus.WriteEnable : '0;

    // R0 is never written, so its storage stays at the reset value forever.
    assign regs_next[0] = '0;
    for (genvar i = 1; i < NREGS; i++) begin : g_next
        assign regs_next[i] = reg_we[i] ? bus.WriteData : regs[i];
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            regs       <= '{default: '0};
            error_flag <= 1'b0;
        end else begin
            regs <= regs_next;
            if (write_multi)
                error_flag <= 1'b1;
        end
    end

    // reg_we is already cleared during Reset and for multi-hot vectors, which disables bypass.
    assign bus.ReadS         = read_port(bus.RS, reg_we, bus.WriteData, regs[bus.RS]);
    assign bus.ReadT         = read_port(bus.RT, reg_we, bus.WriteData, regs[bus.RT]);
    assign bus.MultiHotError = error_flag;

endmodule

// File: tb/tb_register_file_16.sv
// Scoreboard bench for register_file_16: expected reads and error flag are
// queued when each cycle's stimulus is driven and popped when outputs are sampled.
module tb_register_file_16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    register_file_16_if #(.WIDTH(16)) bus ();

    register_file_16 #(.WIDTH(16), .NREGS(16)) dut (
        .CLK   (clk),
        .Reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        logic [15:0] val;
    } sb_entry_t;

    sb_entry_t   sb [$];
    logic [15:0] model [16];
    logic        err_model;
    logic        model_valid;
    int          n_tests;
    int          n_fail;

    task automatic check_val(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [3:0] addr, input logic rw,
                                               input logic [15:0] we, input logic [15:0] wd,
                                               input logic rst);
        if (addr == 4'd0)
            return 16'h0000;
        if (rw && !rst && $countones(we) == 1 && we[addr])
            return wd;
        return model[addr];
    endfunction

    // One clock cycle: drive on the falling edge, check mid-low phase, update model at the rising edge.
    task automatic cycle(input string name, input logic rst, input logic rw, input logic [15:0] we,
                         input logic [15:0] wd, input logic [3:0] rs, input logic [3:0] rt);
        sb_entry_t e;
        @(negedge clk);
        reset           = rst;
        bus.RegWrite    = rw;
        bus.WriteEnable = we;
        bus.WriteData   = wd;
        bus.RS          = rs;
        bus.RT          = rt;
        if (model_valid) begin
            sb.push_back('{{name, "/ReadS"}, model_read(rs, rw, we, wd, rst)});
            sb.push_back('{{name, "/ReadT"}, model_read(rt, rw, we, wd, rst)});
            sb.push_back('{{name, "/Err"}, {15'd0, err_model}});
        end
        #2;
        if (model_valid) begin
            e = sb.pop_front(); check_val(e.tag, bus.ReadS, e.val);
            e = sb.pop_front(); check_val(e.tag, bus.ReadT, e.val);
            e = sb.pop_front(); check_val(e.tag, {15'd0, bus.MultiHotError}, e.val);
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 16; i++) model[i] = 16'h0000;
            err_model   = 1'b0;
            model_valid = 1'b1;
        end else if (rw) begin
            if ($countones(we) == 1) begin
                for (int i = 1; i < 16; i++)
                    if (we[i[3:0]]) model[i] = wd;
            end else if ($countones(we) >= 2) begin
                err_model = 1'b1;
            end
        end
    endtask

    initial begin
        logic [15:0] we_r;
        n_tests = 0;
        n_fail = 0;
        model_valid = 1'b0;
        err_model = 1'b0;
        reset = 1'b0;
        bus.RegWrite = 1'b0;
        bus.WriteEnable = '0;
        bus.WriteData = '0;
        bus.RS = '0;
        bus.RT = '0;

        cycle("reset",      1, 0, 16'h0000, 16'h0000, 0, 0);
        cycle("rst_state",  0, 0, 16'h0000, 16'h0000, 3, 15);
        cycle("rst_state2", 0, 0, 16'h0000, 16'h0000, 0, 9);

        cycle("wr_r5",      0, 1, 16'h0020, 16'h1234, 5, 6);
        cycle("rd_r5",      0, 0, 16'h0000, 16'h0000, 5, 6);

        cycle("byp_r3",     0, 1, 16'h0008, 16'hBEEF, 3, 3);
        cycle("rd_r3",      0, 0, 16'h0000, 16'h0000, 3, 5);

        cycle("wr_r0",      0, 1, 16'h0001, 16'hFFFF, 0, 0);
        cycle("rd_r0",      0, 0, 16'h0000, 16'h0000, 0, 3);

        cycle("zero_hot",   0, 1, 16'h0000, 16'h9999, 5, 3);
        cycle("zero_hot_rd",0, 0, 16'h0000, 16'h0000, 5, 3);

        cycle("wr_r1",      0, 1, 16'h0002, 16'h1111, 1, 2);
        cycle("wr_r2",      0, 1, 16'h0004, 16'h2222, 1, 2);
        cycle("multi",      0, 1, 16'h0006, 16'hAAAA, 1, 2);
        cycle("multi_after",0, 0, 16'h0000, 16'h0000, 1, 2);
        cycle("sticky_wr",  0, 1, 16'h0010, 16'h4444, 4, 1);
        cycle("sticky_rd",  0, 0, 16'h0000, 16'h0000, 4, 2);
        cycle("err_clear",  1, 0, 16'h0000, 16'h0000, 4, 1);
        cycle("err_cleared",0, 0, 16'h0000, 16'h0000, 4, 1);

        cycle("wr_r7",      0, 1, 16'h0080, 16'h1357, 0, 0);
        cycle("gate_r7",    0, 0, 16'h0080, 16'h5555, 7, 7);
        cycle("gate_r7_rd", 0, 0, 16'h0000, 16'h0000, 7, 0);
        cycle("gate_ffff",  0, 0, 16'hFFFF, 16'hABCD, 7, 1);
        cycle("gate_err",   0, 0, 16'h0000, 16'h0000, 7, 1);

        cycle("b2b_1",      0, 1, 16'h0800, 16'h0101, 11, 11);
        cycle("b2b_2",      0, 1, 16'h0800, 16'h0202, 11, 0);
        cycle("b2b_rd",     0, 0, 16'h0000, 16'h0000, 11, 11);

        cycle("wr_r9",      0, 1, 16'h0200, 16'h0F0F, 9, 7);
        cycle("rst_wr_r9",  1, 1, 16'h0200, 16'h7777, 9, 9);
        cycle("post_rst",   0, 0, 16'h0000, 16'h0000, 9, 7);
        cycle("post_rst2",  0, 0, 16'h0000, 16'h0000, 11, 5);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                0:       we_r = 16'h0000;
                1:       we_r = 16'($urandom);
                default: we_r = 16'h0001 << $urandom_range(0, 15);
            endcase
            cycle($sformatf("rand%0d", n), ($urandom_range(0, 29) == 0), 1'($urandom),
                  we_r, 16'($urandom), 4'($urandom), 4'($urandom));
        end

        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
